// File: rtl/bin_to_bcd_seq_pkg.sv
// bin_to_bcd_seq_pkg
// Shared constants for the sequential binary-to-BCD converter: FSM state
// encodings, default digit count, nibble width and the saturation digit.
package bin_to_bcd_seq_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Datapath geometry
    localparam int DIGITS_DEF = 4;
    localparam int NIB_W      = 4;

    // Digit shown in every position when the input is out of range
    localparam logic [NIB_W-1:0] SAT_NIBBLE = 4'h9;

    // Largest value representable with the given number of decimal digits
    function automatic int max_val(input int digits);
        int v;
        v = 1;
        for (int i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// bcd_add3
// Combinational double-dabble nibble adjuster: any digit of 5 or more gets
// 3 added so that the following left shift carries correctly into the next
// decimal digit.
module bcd_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    output logic [NIB_W-1:0] nib_o
);

    assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
// Sequential shift-add-3 binary-to-BCD converter feeding the 7-segment scan
// driver. One conversion per BIN_W+2 cycles; the result registers (BCD, OVF,
// BLANK) only change on completion or reset, so the display never sees
// intermediate digits.
// Optional build macro: BCD_LEADING_BLANK_EN enables the leading-zero blank
// mask on BLANK; without it BLANK is tied low.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W   = 14,
    parameter int DIGITS  = DIGITS_DEF,
    parameter int MAX_VAL = max_val(DIGITS)
) (
    input  logic                    CLK100MHZ,
    input  logic                    RST,
    input  logic [BIN_W-1:0]        BIN,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic [NIB_W*DIGITS-1:0] BCD,
    output logic                    OUT_VALID,
    output logic                    OVF,
    output logic [DIGITS-1:0]       BLANK
);

    localparam int          ACC_W     = NIB_W * DIGITS;
    localparam int          CNT_W     = $clog2(BIN_W + 1);
    localparam logic [31:0] MAX_VAL_W = MAX_VAL;

    logic [1:0]       state_q,     state_d;
    logic [BIN_W-1:0] shift_q,     shift_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             ovf_pend_q,  ovf_pend_d;
    logic [ACC_W-1:0] bcd_q,       bcd_d;
    logic             ovf_q,       ovf_d;
    logic             out_valid_q, out_valid_d;

    // Working accumulator after the per-digit add-3 correction
    logic [ACC_W-1:0] acc_adj;

    genvar g;
    for (g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (acc_q[g*NIB_W +: NIB_W]),
            .nib_o (acc_adj[g*NIB_W +: NIB_W])
        );
    end

`ifdef BCD_LEADING_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic [DIGITS-1:0] blank_calc;

    // Leading-zero mask of the finished accumulator; the ones digit is never blanked
    always_comb begin
        logic higher_zero;
        higher_zero   = 1'b1;
        blank_calc    = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            higher_zero   = higher_zero & (acc_q[i*NIB_W +: NIB_W] == '0);
            blank_calc[i] = higher_zero;
        end
    end
`endif

    // Next-state and datapath logic for the IDLE/CONV/DONE sequencer
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch behind.
        state_d     = state_q;
        shift_d     = shift_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_pend_d  = ovf_pend_q;
        bcd_d       = bcd_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
`ifdef BCD_LEADING_BLANK_EN
        blank_d     = blank_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    shift_d    = BIN;
                    acc_d      = '0;
                    ovf_pend_d = (32'(BIN) > MAX_VAL_W);
                    cnt_d      = CNT_W'(BIN_W);
                    state_d    = ST_CONV;
                end
            end

            ST_CONV: begin
                acc_d      = {acc_adj[ACC_W-2:0], shift_q[BIN_W-1]};
                shift_d    = shift_q << 1;
                // A carry out of the top digit can only occur for out-of-range
                // inputs; folding it in keeps the saturation decision robust.
                ovf_pend_d = ovf_pend_q | acc_adj[ACC_W-1];
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                bcd_d       = ovf_pend_q ? {DIGITS{SAT_NIBBLE}} : acc_q;
                ovf_d       = ovf_pend_q;
                out_valid_d = 1'b1;
`ifdef BCD_LEADING_BLANK_EN
                blank_d     = ovf_pend_q ? '0 : blank_calc;
`endif
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous active-high reset
    always_ff @(posedge CLK100MHZ) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (RST) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_pend_q  <= 1'b0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef BCD_LEADING_BLANK_EN
            blank_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_pend_q  <= ovf_pend_d;
            bcd_q       <= bcd_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
`ifdef BCD_LEADING_BLANK_EN
            blank_q     <= blank_d;
`endif
        end
    end

    assign IN_READY  = (state_q == ST_IDLE);
    assign BCD       = bcd_q;
    assign OVF       = ovf_q;
    assign OUT_VALID = out_valid_q;
`ifdef BCD_LEADING_BLANK_EN
    assign BLANK     = blank_q;
`else
    assign BLANK     = '0;
`endif

endmodule
